// File: rtl/frame_commit_if.sv
// Memory-side bus of the frame sequencer: next-state RAM read/clear ports and VRAM write port.
// The sequencer holds the master modport; the RAM/VRAM wrapper holds the slave modport.
interface frame_commit_if #(
    parameter int ADDR_WIDTH = 19,
    parameter int DATA_WIDTH = 2
);
    logic [ADDR_WIDTH-1:0] ram_rd_address;
    logic [DATA_WIDTH-1:0] ram_rd_data;
    logic [ADDR_WIDTH-1:0] ram_wr_address;
    logic [DATA_WIDTH-1:0] ram_wr_data;
    logic                  ram_wr_en;
    logic [ADDR_WIDTH-1:0] vram_wr_address;
    logic [DATA_WIDTH-1:0] vram_wr_data;
    logic                  vram_wr_en;

    modport master (
        output ram_rd_address,
        input  ram_rd_data,
        output ram_wr_address,
        output ram_wr_data,
        output ram_wr_en,
        output vram_wr_address,
        output vram_wr_data,
        output vram_wr_en
    );

    modport slave (
        input  ram_rd_address,
        output ram_rd_data,
        input  ram_wr_address,
        input  ram_wr_data,
        input  ram_wr_en,
        input  vram_wr_address,
        input  vram_wr_data,
        input  vram_wr_en
    );
endinterface

// File: rtl/frame_commit.sv
// Frame sequencer: starts the next-state engine on a divided frame tick, then copies RAM to VRAM
// while clearing RAM. Define OCCUPANCY_COUNT_EN to add the particle_count_o occupancy output.
//
// state     | meaning
// ----------+-------------------------------------------------------------
// IDLE      | waiting for frame ticks, dividing them by FRAME_DIV
// START     | one-cycle ready_o pulse to the engine
// WAIT_DONE | engine running, waiting for done_i
// COPY      | issuing RAM read addresses 0..N-1, writing the previous cell
// FLUSH     | final VRAM write / RAM clear for cell N-1
module frame_commit #(
    parameter int ACTIVE_COLUMNS = 640,
    parameter int ACTIVE_ROWS    = 480,
    parameter int ADDR_WIDTH     = $clog2(ACTIVE_COLUMNS * ACTIVE_ROWS),
    parameter int DATA_WIDTH     = 2,
    parameter int FRAME_DIV      = 1
) (
    input  logic            clk_i,
    input  logic            reset_n_i,
    input  logic            frame_tick_i,
    input  logic            done_i,
    output logic            ready_o,
    output logic            busy_o,
    output logic            missed_tick_o,
    frame_commit_if.master  mem
`ifdef OCCUPANCY_COUNT_EN
    ,
    output logic [ADDR_WIDTH:0] particle_count_o
`endif
);

    localparam int CELLS = ACTIVE_COLUMNS * ACTIVE_ROWS;
    localparam int DIV_W = (FRAME_DIV > 1) ? $clog2(FRAME_DIV) : 1;
    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(CELLS - 1);
    localparam logic [DIV_W-1:0]      DIV_LAST  = DIV_W'(FRAME_DIV - 1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        WAIT_DONE,
        COPY,
        FLUSH
    } state_t;

    state_t                state_q, state_d;
    logic [DIV_W-1:0]      div_q, div_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic                  wr_valid_q;
    logic [ADDR_WIDTH-1:0] wr_addr_q;
    logic [DATA_WIDTH-1:0] wr_data;

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_q <= IDLE;
            div_q   <= '0;
            addr_q  <= '0;
        end else begin
            state_q <= state_d;
            div_q   <= div_d;
            addr_q  <= addr_d;
        end
    end

    always_comb begin
        state_d = state_q;
        div_d   = div_q;
        addr_d  = addr_q;
        unique case (state_q)
            IDLE: begin
                if (frame_tick_i) begin
                    if (div_q == DIV_LAST) begin
                        div_d   = '0;
                        state_d = START;
                    end else begin
                        div_d = div_q + 1'b1;
                    end
                end
            end
            START: state_d = WAIT_DONE;
            WAIT_DONE: begin
                if (done_i) begin
                    addr_d  = '0;
                    state_d = COPY;
                end
            end
            COPY: begin
                if (addr_q == LAST_ADDR) begin
                    state_d = FLUSH;
                end else begin
                    addr_d = addr_q + 1'b1;
                end
            end
            FLUSH:   state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Write stage trails the read address by one cycle to absorb the RAM read latency.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            wr_valid_q <= 1'b0;
            wr_addr_q  <= '0;
        end else begin
            wr_valid_q <= (state_q == COPY);
            wr_addr_q  <= (state_q == COPY) ? addr_q : '0;
        end
    end

    assign wr_data = wr_valid_q ? mem.ram_rd_data : '0;

    assign ready_o       = (state_q == START);
    assign busy_o        = (state_q != IDLE);
    assign missed_tick_o = frame_tick_i && (state_q != IDLE);

    assign mem.ram_rd_address  = (state_q == COPY) ? addr_q : '0;
    assign mem.vram_wr_en      = wr_valid_q;
    assign mem.vram_wr_address = wr_addr_q;
    assign mem.vram_wr_data    = wr_data;
    assign mem.ram_wr_en       = wr_valid_q;
    assign mem.ram_wr_address  = wr_addr_q;
    assign mem.ram_wr_data     = '0;

`ifdef OCCUPANCY_COUNT_EN
    logic [ADDR_WIDTH:0] acc_q;
    logic [ADDR_WIDTH:0] acc_inc;
    logic [ADDR_WIDTH:0] count_q;

    assign acc_inc = acc_q + {{ADDR_WIDTH{1'b0}}, (wr_valid_q && (wr_data != '0))};

    // The published count only moves when a full copy has completed.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            acc_q   <= '0;
            count_q <= '0;
        end else begin
            if (state_q == WAIT_DONE && done_i) begin
                acc_q <= '0;
            end else if (wr_valid_q) begin
                acc_q <= acc_inc;
            end
            if (state_q == FLUSH) begin
                count_q <= acc_inc;
            end
        end
    end

    assign particle_count_o = count_q;
`endif

endmodule

// File: tb/tb_frame_commit.sv
// Scoreboarded bench for frame_commit on a 4x3 grid with a 1-cycle-latency dual-port RAM model.
// A second instance with FRAME_DIV=3 exercises the tick divider.
module tb_frame_commit;

    localparam int COLS = 4;
    localparam int ROWS = 3;
    localparam int N    = COLS * ROWS;
    localparam int AW   = 4;
    localparam int DW   = 2;

    typedef struct packed {
        logic [AW-1:0] a;
        logic [DW-1:0] d;
    } wr_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic reset_n, tick, done, ready, busy, missed;
    logic tick2, ready2, busy2, missed2;
    logic done2 = 1'b0;

    frame_commit_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) mem ();
    frame_commit_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) mem2 ();

`ifdef OCCUPANCY_COUNT_EN
    logic [AW:0] pcount, pcount2;
    int count_exp = 0;
`endif

    frame_commit #(
        .ACTIVE_COLUMNS(COLS), .ACTIVE_ROWS(ROWS), .ADDR_WIDTH(AW),
        .DATA_WIDTH(DW), .FRAME_DIV(1)
    ) dut (
        .clk_i(clk), .reset_n_i(reset_n), .frame_tick_i(tick), .done_i(done),
        .ready_o(ready), .busy_o(busy), .missed_tick_o(missed), .mem(mem)
`ifdef OCCUPANCY_COUNT_EN
        , .particle_count_o(pcount)
`endif
    );

    frame_commit #(
        .ACTIVE_COLUMNS(COLS), .ACTIVE_ROWS(ROWS), .ADDR_WIDTH(AW),
        .DATA_WIDTH(DW), .FRAME_DIV(3)
    ) dut_div (
        .clk_i(clk), .reset_n_i(reset_n), .frame_tick_i(tick2), .done_i(done2),
        .ready_o(ready2), .busy_o(busy2), .missed_tick_o(missed2), .mem(mem2)
`ifdef OCCUPANCY_COUNT_EN
        , .particle_count_o(pcount2)
`endif
    );

    assign mem2.ram_rd_data = '0;

    // Engine stand-in for the divider instance: done one cycle after ready.
    always @(posedge clk) done2 <= ready2;

    logic [DW-1:0] ram      [N];
    logic [DW-1:0] vram     [N];
    logic [DW-1:0] load_img [N];
    logic          load_req = 1'b0;

    always @(posedge clk) begin
        mem.ram_rd_data <= (32'(mem.ram_rd_address) < N) ? ram[mem.ram_rd_address] : '0;
        if (load_req) begin
            for (int i = 0; i < N; i++) ram[i] <= load_img[i];
        end else if (mem.ram_wr_en && 32'(mem.ram_wr_address) < N) begin
            ram[mem.ram_wr_address] <= mem.ram_wr_data;
        end
        if (mem.vram_wr_en && 32'(mem.vram_wr_address) < N)
            vram[mem.vram_wr_address] <= mem.vram_wr_data;
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int  vectors = 0;
    int  miscompares = 0;
    wr_t exp_q[$];
    int  exp_rdy_q[$];
    int  n_writes = 0, n_missed = 0, n_missed2 = 0;
    int  first_wr_cyc = 0, last_wr_cyc = 0;
    int  tick2_idx = 0;
    bit  sb_off = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor: pops the scoreboard on every VRAM write, checks idle bus values.
    initial begin
        wr_t e;
        forever begin
            @(negedge clk);
            if (mem.vram_wr_en) begin
                n_writes++;
                last_wr_cyc = cyc;
                if (mem.vram_wr_address == '0) first_wr_cyc = cyc;
                if (!sb_off) begin
                    if (exp_q.size() == 0) begin
                        chk("unexpected_vram_write_addr", 32'(mem.vram_wr_address), 32'hFFFF_FFFF);
                    end else begin
                        e = exp_q.pop_front();
                        chk("vram_wr_address", 32'(mem.vram_wr_address), 32'(e.a));
                        chk("vram_wr_data", 32'(mem.vram_wr_data), 32'(e.d));
                    end
                end
                chk("ram_clear_strobe", 32'(mem.ram_wr_en), 1);
                chk("ram_clear_address", 32'(mem.ram_wr_address), 32'(mem.vram_wr_address));
                chk("ram_clear_data", 32'(mem.ram_wr_data), 0);
            end else begin
                chk("idle_write_bus", {mem.ram_wr_en, 3'b0, 4'(mem.ram_wr_address),
                    6'(mem.ram_wr_data), 4'(mem.vram_wr_address), 10'(mem.vram_wr_data)}, 0);
            end
            if (!busy) chk("idle_rd_address", 32'(mem.ram_rd_address), 0);
            if (missed)  n_missed++;
            if (missed2) n_missed2++;
            if (ready2) begin
                if (exp_rdy_q.size() == 0) chk("unexpected_div_ready_tick", tick2_idx, 0);
                else chk("div_ready_tick", tick2_idx, exp_rdy_q.pop_front());
            end
        end
    end

    task automatic load_ram(input int pattern);
        for (int i = 0; i < N; i++) begin
            case (pattern)
                0:       load_img[i] = DW'(i % 4);
                1:       load_img[i] = DW'((i * 3 + 1) % 4);
                2:       load_img[i] = DW'((i + 2) % 4);
                3:       load_img[i] = (i == 1) ? 2'd1 : (i == 4) ? 2'd2 : (i == 6) ? 2'd3 :
                                       (i == 9) ? 2'd1 : (i == 11) ? 2'd2 : 2'd0;
                default: load_img[i] = 2'd3;
            endcase
        end
        @(posedge clk); #1 load_req = 1'b1;
        @(posedge clk); #1 load_req = 1'b0;
    endtask

    task automatic run_gen(input bit overrun, input bit tick_with_done, input bit stray_done);
        int wr0, m0, d, nz;
        bit got;
        nz = 0;
        for (int i = 0; i < N; i++) begin
            exp_q.push_back({AW'(i), load_img[i]});
            if (load_img[i] != '0) nz++;
        end
        wr0 = n_writes;
        m0  = n_missed;
        @(posedge clk); #1 tick = 1'b1;
        @(posedge clk); #1 tick = 1'b0;
        chk("ready_after_tick", 32'(ready), 1);
        for (int c = 0; c < 5; c++) begin
            @(posedge clk); #1;
            tick = overrun && (c == 1);
            if (c == 4) begin
                done = 1'b1;
                tick = tick_with_done;
            end
        end
        @(posedge clk); #1 done = 1'b0; tick = 1'b0;
        d = cyc;
`ifdef OCCUPANCY_COUNT_EN
        chk("count_hold_start", 32'(pcount), 32'(count_exp));
`endif
        for (int c = 0; c < 4; c++) begin
            @(posedge clk); #1;
            tick = overrun && (c == 3);
            done = stray_done && (c == 3);
        end
        @(posedge clk); #1 tick = 1'b0; done = 1'b0;
`ifdef OCCUPANCY_COUNT_EN
        chk("count_hold_copy", 32'(pcount), 32'(count_exp));
`endif
        got = 1'b0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (!busy) begin
                got = 1'b1;
                break;
            end
        end
        chk("busy_falls", 32'(got), 1);
        if (got) begin
            chk("busy_fall_cycle", cyc, last_wr_cyc + 1);
            chk("first_write_cycle", first_wr_cyc, d + 1);
        end
        chk("write_count", n_writes - wr0, N);
        chk("writes_missing", exp_q.size(), 0);
        exp_q.delete();
        chk("missed_ticks", n_missed - m0, 2 * int'(overrun) + int'(tick_with_done));
        for (int i = 0; i < N; i++) begin
            chk("ram_cleared", 32'(ram[i]), 0);
            chk("vram_contents", 32'(vram[i]), 32'(load_img[i]));
        end
`ifdef OCCUPANCY_COUNT_EN
        chk("particle_count", 32'(pcount), nz);
        count_exp = nz;
`endif
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int w0;
        reset_n = 1'b0;
        tick    = 1'b0;
        done    = 1'b0;
        tick2   = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_busy", 32'(busy), 0);
        chk("reset_ready", 32'(ready), 0);
        chk("reset_vram_en", 32'(mem.vram_wr_en), 0);
        reset_n = 1'b1;

        // Divider: ticks 3 and 6 of 7 start a generation.
        exp_rdy_q.push_back(3);
        exp_rdy_q.push_back(6);
        for (int t = 1; t <= 7; t++) begin
            tick2_idx = t;
            @(posedge clk); #1 tick2 = 1'b1;
            @(posedge clk); #1 tick2 = 1'b0;
            repeat (25) @(posedge clk);
        end
        chk("div_ready_missing", exp_rdy_q.size(), 0);
        chk("div_missed", n_missed2, 0);

        load_ram(0);
        run_gen(1'b0, 1'b0, 1'b0);

        // Stray done in IDLE.
        w0 = n_writes;
        @(posedge clk); #1 done = 1'b1;
        @(posedge clk); #1 done = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        chk("stray_done_idle_busy", 32'(busy), 0);
        chk("stray_done_idle_writes", n_writes - w0, 0);

        load_ram(1);
        run_gen(1'b1, 1'b0, 1'b1);
        load_ram(2);
        run_gen(1'b0, 1'b1, 1'b0);

        // Reset in the middle of a copy.
        load_ram(0);
        sb_off = 1'b1;
        @(posedge clk); #1 tick = 1'b1;
        @(posedge clk); #1 tick = 1'b0;
        repeat (5) @(posedge clk);
        #1 done = 1'b1;
        @(posedge clk); #1 done = 1'b0;
        repeat (4) @(posedge clk);
        #3 reset_n = 1'b0;
        #1;
        chk("midreset_busy", 32'(busy), 0);
        chk("midreset_ready", 32'(ready), 0);
        chk("midreset_vram_en", 32'(mem.vram_wr_en), 0);
        chk("midreset_ram_en", 32'(mem.ram_wr_en), 0);
        chk("midreset_rd_addr", 32'(mem.ram_rd_address), 0);
        chk("midreset_vram_addr", 32'(mem.vram_wr_address), 0);
`ifdef OCCUPANCY_COUNT_EN
        chk("midreset_count", 32'(pcount), 0);
        count_exp = 0;
`endif
        @(posedge clk); #1 reset_n = 1'b1;
        sb_off = 1'b0;
        load_ram(0);
        run_gen(1'b0, 1'b0, 1'b0);

        // Occupancy images: 5 nonzero cells, then all nonzero.
        load_ram(3);
        run_gen(1'b0, 1'b0, 1'b0);
        load_ram(4);
        run_gen(1'b0, 1'b0, 1'b0);

        repeat (3) @(posedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
